// File: rtl/rr_arb2_sel.sv
// Two-source round-robin arbiter feeding a one-entry output buffer.
// Drives the 2:1 mux select and registers the granted beat with its source index.
module rr_arb2_sel #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in0_valid,
   input  logic [W-1:0] in0_data,
   output logic         in0_ready,
   input  logic         in1_valid,
   input  logic [W-1:0] in1_data,
   output logic         in1_ready,
   output logic         S,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_src,
   input  logic         out_ready
);

   // Handshake: a beat moves on a rising edge where valid & ready are both high;
   // readies are derived from valids (never the reverse), and a source holds
   // valid and data stable until its beat is accepted.

   logic last_grant;
   logic load_en;
   logic g0;
   logic g1;
   logic take;

   always_comb begin
      load_en   = !out_valid | out_ready;
      g0        = in0_valid & (!in1_valid | last_grant);
      g1        = in1_valid & (!in0_valid | !last_grant);
      S         = g1;
      // Readies are forced low while reset is held, since the buffer is being cleared.
      in0_ready = load_en & g0 & !rst;
      in1_ready = load_en & g1 & !rst;
      take      = load_en & (g0 | g1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= 1'b0;
         last_grant <= 1'b1;
      end else if (take) begin
         out_data   <= g1 ? in1_data : in0_data;
         out_src    <= g1;
         out_valid  <= 1'b1;
         last_grant <= g1;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb2_sel.sv
// Scoreboard bench for rr_arb2_sel: directed vectors push hand-computed beats,
// a monitor pops and compares every output handshake.
module tb_rr_arb2_sel;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in0_valid, in1_valid, out_ready;
   logic [W-1:0] in0_data, in1_data;
   logic         in0_ready, in1_ready, S, out_valid, out_src;
   logic [W-1:0] out_data;

   logic [W:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   rr_arb2_sel #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
      .S(S), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every accepted output beat must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {27'd0, out_src, out_data}, 32'hFFFF_FFFF);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("out_beat", {27'd0, out_src, out_data}, {27'd0, e});
         end
      end
   end

   // Drive one cycle (called at posedge+1), check readies/select, push granted beat.
   task automatic step(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1,
                       input logic ordy, input logic er0, input logic er1,
                       output logic r0, output logic r1);
      in0_valid = v0; in0_data = d0;
      in1_valid = v1; in1_data = d1;
      out_ready = ordy;
      #1;
      r0 = in0_ready;
      r1 = in1_ready;
      check("in0_ready", {31'd0, in0_ready}, {31'd0, er0});
      check("in1_ready", {31'd0, in1_ready}, {31'd0, er1});
      if (er0 | er1) check("sel", {31'd0, S}, {31'd0, er1});
      if (er0) exp_q.push_back({1'b0, d0});
      if (er1) exp_q.push_back({1'b1, d1});
      @(posedge clk);
      #1;
   endtask

   logic r0, r1;
   logic p0, p1, ov_m, last_m, le, ordy, er0, er1;
   logic [W-1:0] pd0, pd1;
   int wait0, wait1;

   initial begin
      rst = 1'b1;
      in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {28'd0, out_data}, 0);
      check("rst_out_src", {31'd0, out_src}, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Asynchronous reset between edges with a beat buffered.
      step(1, 4'h3, 0, 4'h0, 0, 1, 0, r0, r1);
      check("pre_rst_valid", {31'd0, out_valid}, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 0);
      check("mid_rst_out_data", {28'd0, out_data}, 0);
      check("mid_rst_out_src", {31'd0, out_src}, 0);
      check("mid_rst_in0_ready", {31'd0, in0_ready}, 0);
      exp_q.delete();
      in0_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      #1;
      check("idle_S", {31'd0, S}, 0);
      check("idle_in0_ready", {31'd0, in0_ready}, 0);
      check("idle_in1_ready", {31'd0, in1_ready}, 0);
      @(posedge clk);
      #1;

      // Contention: first winner is source 0, then strict alternation.
      step(1, 4'hA, 1, 4'h5, 1, 1, 0, r0, r1);
      step(1, 4'hA, 1, 4'h5, 1, 0, 1, r0, r1);
      step(1, 4'hA, 1, 4'h5, 1, 1, 0, r0, r1);
      step(1, 4'hA, 1, 4'h5, 1, 0, 1, r0, r1);
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);

      // Single source, back-to-back.
      step(1, 4'h3, 0, 4'h0, 1, 1, 0, r0, r1);
      step(1, 4'h9, 0, 4'h0, 1, 1, 0, r0, r1);
      step(1, 4'hF, 0, 4'h0, 1, 1, 0, r0, r1);
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);

      // Backpressure holding C; last grant was source 0, so source 1 goes next.
      step(1, 4'hC, 0, 4'h0, 1, 1, 0, r0, r1);
      for (int i = 0; i < 3; i++) begin
         step(1, 4'hA, 1, 4'h5, 0, 0, 0, r0, r1);
         check("bp_out_data", {28'd0, out_data}, 32'hC);
         check("bp_out_valid", {31'd0, out_valid}, 1);
      end
      step(1, 4'hA, 1, 4'h5, 1, 0, 1, r0, r1);
      step(1, 4'hA, 0, 4'h0, 1, 1, 0, r0, r1);
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);

      // Drain and load in the same cycle.
      step(1, 4'h2, 0, 4'h0, 0, 1, 0, r0, r1);
      step(0, 4'h0, 1, 4'h7, 1, 0, 1, r0, r1);
      check("dl_out_valid", {31'd0, out_valid}, 1);
      check("dl_out_data", {28'd0, out_data}, 32'h7);
      check("dl_out_src", {31'd0, out_src}, 1);
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);

      // Random soak against a small reference model; last grant is now source 1.
      ov_m = 0; last_m = 1; p0 = 0; p1 = 0; pd0 = 0; pd1 = 0; wait0 = 0; wait1 = 0;
      for (int c = 0; c < 200; c++) begin
         if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1; pd0 = W'($urandom_range(0, 15)); end
         if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1; pd1 = W'($urandom_range(0, 15)); end
         ordy = ($urandom_range(0, 3) != 0);
         le   = !ov_m | ordy;
         er0  = le & p0 & (!p1 | last_m);
         er1  = le & p1 & (!p0 | !last_m);
         step(p0, pd0, p1, pd1, ordy, er0, er1, r0, r1);
         if (p0 && r1) wait0++;
         if (p1 && r0) wait1++;
         check("fair0", wait0 <= 1, 1);
         check("fair1", wait1 <= 1, 1);
         if (r0) wait0 = 0;
         if (r1) wait1 = 0;
         if (er0 | er1) begin ov_m = 1; last_m = er1; end
         else if (ordy) ov_m = 0;
         if (er0) p0 = 0;
         if (er1) p1 = 0;
      end
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);
      step(0, 4'h0, 0, 4'h0, 1, 0, 0, r0, r1);
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
